// File: rtl/tjmono_rx_fifo_arbiter_if.sv
// FIFO handshake bundle of the TJ-Monopix receiver merge stage.
// Carries the two show-ahead source ports and the merged show-ahead output port.
// The master modport is the arbiter's view: it pops the sources and presents the merged port.
// The slave modport is the environment's view: the receivers and the readout consumer.
interface tjmono_rx_fifo_arbiter_if;
  logic        IN0_FIFO_READ;
  logic        IN0_FIFO_EMPTY;
  logic [31:0] IN0_FIFO_DATA;
  logic        IN1_FIFO_READ;
  logic        IN1_FIFO_EMPTY;
  logic [31:0] IN1_FIFO_DATA;
  logic        OUT_FIFO_READ;
  logic        OUT_FIFO_EMPTY;
  logic [31:0] OUT_FIFO_DATA;

  modport master (
    output IN0_FIFO_READ,
    input  IN0_FIFO_EMPTY,
    input  IN0_FIFO_DATA,
    output IN1_FIFO_READ,
    input  IN1_FIFO_EMPTY,
    input  IN1_FIFO_DATA,
    input  OUT_FIFO_READ,
    output OUT_FIFO_EMPTY,
    output OUT_FIFO_DATA
  );

  modport slave (
    input  IN0_FIFO_READ,
    output IN0_FIFO_EMPTY,
    output IN0_FIFO_DATA,
    input  IN1_FIFO_READ,
    output IN1_FIFO_EMPTY,
    output IN1_FIFO_DATA,
    output OUT_FIFO_READ,
    input  OUT_FIFO_EMPTY,
    input  OUT_FIFO_DATA
  );
endinterface

// File: rtl/tjmono_rx_fifo_arbiter.sv
// Merges the show-ahead FIFO ports of two TJ-Monopix receivers into one show-ahead port.
// Round-robin arbitration with a bounded burst per source, a 2-entry output buffer
// giving one word per cycle, and per-source word counters. Words pass unchanged.
module tjmono_rx_fifo_arbiter #(
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [1:0]           ENABLE,
  input  logic                 CNT_CLR,
  tjmono_rx_fifo_arbiter_if.master bus,
  output logic [CNT_WIDTH-1:0] WORD_CNT0,
  output logic [CNT_WIDTH-1:0] WORD_CNT1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  state_t         state_r;
  state_t         state_nxt_s;
  logic           last_r;        // source served most recently (1 after reset so source 0 wins first)
  logic           last_nxt_s;
  logic [7:0]     burst_r;
  logic [7:0]     burst_nxt_s;

  logic [31:0]    mem_r [2];
  logic           rd_ptr_r;
  logic           wr_ptr_r;
  logic [1:0]     occ_r;

  logic [CNT_WIDTH-1:0] cnt0_r;
  logic [CNT_WIDTH-1:0] cnt1_r;

  logic           avail0_s;
  logic           avail1_s;
  logic           out_empty_s;
  logic           out_pop_s;
  logic           room_s;
  logic           pop0_s;
  logic           pop1_s;
  logic           push_s;
  logic [31:0]    push_data_s;
  logic           serving1_s;
  logic           cur_avail_s;
  logic           oth_avail_s;
  logic           cur_pop_s;
  logic [7:0]     burst_post_s;
  state_t         oth_state_s;

  // Handshake decode: availability, buffer room and source pops (none while in reset)
  always_comb begin
    avail0_s     = ENABLE[0] & ~bus.IN0_FIFO_EMPTY;
    avail1_s     = ENABLE[1] & ~bus.IN1_FIFO_EMPTY;
    out_empty_s  = (occ_r == 2'd0);
    out_pop_s    = bus.OUT_FIFO_READ & ~out_empty_s;
    room_s       = (occ_r != 2'd2) | out_pop_s;
    pop0_s       = (state_r == SERVE0) & avail0_s & room_s & ~BUS_RST;
    pop1_s       = (state_r == SERVE1) & avail1_s & room_s & ~BUS_RST;
    push_s       = pop0_s | pop1_s;
    if (pop0_s) begin
      push_data_s = bus.IN0_FIFO_DATA;
    end else begin
      push_data_s = bus.IN1_FIFO_DATA;
    end
    serving1_s   = (state_r == SERVE1);
    cur_avail_s  = serving1_s ? avail1_s : avail0_s;
    oth_avail_s  = serving1_s ? avail0_s : avail1_s;
    oth_state_s  = serving1_s ? SERVE0 : SERVE1;
    cur_pop_s    = push_s;
    burst_post_s = burst_r + {7'd0, cur_pop_s};
  end

  // Drive the port bundle from the decode and the buffer head
  always_comb begin
    bus.IN0_FIFO_READ  = pop0_s;
    bus.IN1_FIFO_READ  = pop1_s;
    bus.OUT_FIFO_EMPTY = out_empty_s;
    if (out_empty_s) begin
      bus.OUT_FIFO_DATA = 32'd0;
    end else begin
      bus.OUT_FIFO_DATA = mem_r[rd_ptr_r];
    end
  end

  // Arbiter next state: round-robin pick from IDLE, burst bookkeeping and exit rules while serving
  always_comb begin
    state_nxt_s = state_r;
    burst_nxt_s = burst_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        burst_nxt_s = 8'd0;
        if (last_r) begin
          if (avail0_s) begin
            state_nxt_s = SERVE0;
          end else if (avail1_s) begin
            state_nxt_s = SERVE1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          if (avail1_s) begin
            state_nxt_s = SERVE1;
          end else if (avail0_s) begin
            state_nxt_s = SERVE0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
      end
      SERVE0, SERVE1: begin
        if (cur_pop_s) begin
          last_nxt_s = serving1_s;
        end else begin
          last_nxt_s = last_r;
        end
        if (!cur_avail_s) begin
          // Current source dried up or was disabled: hand over, or park in IDLE
          burst_nxt_s = 8'd0;
          if (oth_avail_s) begin
            state_nxt_s = oth_state_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (burst_post_s >= BURST_LIM) begin
          // Burst exhausted: switch only if the other side has something to give
          burst_nxt_s = 8'd0;
          if (oth_avail_s) begin
            state_nxt_s = oth_state_s;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          burst_nxt_s = burst_post_s;
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        burst_nxt_s = 8'd0;
        last_nxt_s  = 1'b1;
      end
    endcase
  end

  // Arbiter state register
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      burst_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      burst_r <= burst_nxt_s;
    end
  end

  // Two-entry in-order output buffer; simultaneous push and pop keep occupancy
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= 32'd0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (out_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, out_pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Per-source word counters; clear wins over a same-cycle pop, otherwise wrap freely
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || CNT_CLR) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else begin
      if (pop0_s) begin
        cnt0_r <= cnt0_r + CNT_WIDTH'(1);
      end
      if (pop1_s) begin
        cnt1_r <= cnt1_r + CNT_WIDTH'(1);
      end
    end
  end

  assign WORD_CNT0 = cnt0_r;
  assign WORD_CNT1 = cnt1_r;

endmodule

// File: tb/tb_tjmono_rx_fifo_arbiter.sv
// Self-checking bench for tjmono_rx_fifo_arbiter: directed scenarios plus a randomized
// run, compared against a queue-based behavioural model of the arbiter.
module tb_tjmono_rx_fifo_arbiter;
  localparam int BMAX = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    enable;
  logic          cnt_clr;
  logic          out_rd;
  logic [CW-1:0] word_cnt0;
  logic [CW-1:0] word_cnt1;

  tjmono_rx_fifo_arbiter_if bus ();

  tjmono_rx_fifo_arbiter #(.BURST_MAX(BMAX), .CNT_WIDTH(CW)) dut (
    .BUS_CLK   (clk),
    .BUS_RST   (rst),
    .ENABLE    (enable),
    .CNT_CLR   (cnt_clr),
    .bus       (bus),
    .WORD_CNT0 (word_cnt0),
    .WORD_CNT1 (word_cnt1)
  );

  always #5 clk = ~clk;

  // source FIFO contents, model state, observation log
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] m_buf[$];
  int          m_serve;   // -1 none, else index of source being served
  int          m_last;
  int          m_burst;
  int          m_cnt0;
  int          m_cnt1;
  logic [31:0] obs_out[$];
  int          obs_tick[$];
  int          tick_no = 0;
  int          errors = 0;
  int          checks = 0;

  logic [1:0]    s_rd, e_rd;
  logic          s_empty, e_empty;
  logic [31:0]   s_data, e_data;
  logic [CW-1:0] s_cnt0, s_cnt1, e_cnt0, e_cnt1;

  task automatic drive_src();
    bus.IN0_FIFO_EMPTY = (q0.size() == 0);
    bus.IN1_FIFO_EMPTY = (q1.size() == 0);
    if (q0.size() != 0) bus.IN0_FIFO_DATA = q0[0];
    else                bus.IN0_FIFO_DATA = 32'h0BAD_0000;
    if (q1.size() != 0) bus.IN1_FIFO_DATA = q1[0];
    else                bus.IN1_FIFO_DATA = 32'h0BAD_0001;
    bus.OUT_FIFO_READ = out_rd;
  endtask

  // One clock cycle: sample DUT, compute model expectation, advance model at the edge.
  task automatic tick();
    bit av0, av1, opop, room, p0, p1, cur, oth;
    drive_src();
    #1;
    s_rd    = {bus.IN1_FIFO_READ, bus.IN0_FIFO_READ};
    s_empty = bus.OUT_FIFO_EMPTY;
    s_data  = bus.OUT_FIFO_DATA;
    s_cnt0  = word_cnt0;
    s_cnt1  = word_cnt1;
    if (!rst && out_rd && !s_empty) begin
      obs_out.push_back(s_data);
      obs_tick.push_back(tick_no);
    end
    av0  = enable[0] && (q0.size() > 0);
    av1  = enable[1] && (q1.size() > 0);
    opop = out_rd && (m_buf.size() > 0);
    room = (m_buf.size() < 2) || opop;
    p0   = !rst && (m_serve == 0) && av0 && room;
    p1   = !rst && (m_serve == 1) && av1 && room;
    e_rd    = {p1, p0};
    e_empty = (m_buf.size() == 0);
    e_data  = e_empty ? 32'd0 : m_buf[0];
    e_cnt0  = m_cnt0[CW-1:0];
    e_cnt1  = m_cnt1[CW-1:0];
    @(posedge clk);
    if (rst) begin
      m_serve = -1; m_last = 1; m_burst = 0; m_cnt0 = 0; m_cnt1 = 0;
      m_buf.delete();
    end else begin
      if (opop) void'(m_buf.pop_front());
      if (p0) m_buf.push_back(q0.pop_front());
      if (p1) m_buf.push_back(q1.pop_front());
      m_cnt0 = cnt_clr ? 0 : (m_cnt0 + int'(p0)) % (1 << CW);
      m_cnt1 = cnt_clr ? 0 : (m_cnt1 + int'(p1)) % (1 << CW);
      if (m_serve < 0) begin
        m_burst = 0;
        if ((m_last == 1) ? av0 : av1)      m_serve = 1 - m_last;
        else if ((m_last == 1) ? av1 : av0) m_serve = m_last;
      end else begin
        cur = (m_serve == 0) ? av0 : av1;
        oth = (m_serve == 0) ? av1 : av0;
        if (p0 || p1) begin
          m_last  = m_serve;
          m_burst = m_burst + 1;
        end
        if (!cur) begin
          m_serve = oth ? 1 - m_serve : -1;
          m_burst = 0;
        end else if (m_burst >= BMAX) begin
          if (oth) m_serve = 1 - m_serve;
          m_burst = 0;
        end
      end
    end
    tick_no++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; out_rd = 1'b0; cnt_clr = 1'b0;
    q0.delete(); q1.delete();
    tick(); tick();
    rst = 1'b0;
    obs_out.delete(); obs_tick.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 2'b11; out_rd = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", s_empty); end
    checks++; if (s_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", s_data); end
    checks++; if (s_rd !== 2'b00) begin errors++; $display("FAIL reset_read: got %b want 00", s_rd); end
    checks++; if (s_cnt0 !== '0 || s_cnt1 !== '0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", s_cnt0, s_cnt1); end
  endtask

  task automatic test_single_source();
    int first_pop, last_pop, npop, first_vis, t;
    do_reset();
    enable = 2'b11; out_rd = 1'b1;
    q0.push_back(32'hA000_0001); q0.push_back(32'hA000_0002); q0.push_back(32'hA000_0003);
    first_pop = -1; last_pop = -1; npop = 0; first_vis = -1;
    for (int i = 0; i < 8; i++) begin
      t = tick_no;
      tick();
      checks++; if (s_rd !== e_rd) begin errors++; $display("FAIL single_rd t=%0d: got %b want %b", t, s_rd, e_rd); end
      if (s_rd[0]) begin
        if (first_pop < 0) first_pop = t;
        last_pop = t; npop++;
      end
      if (!s_empty && first_vis < 0) first_vis = t;
    end
    checks++; if (npop != 3 || last_pop - first_pop != 2) begin errors++; $display("FAIL single_pops: got %0d pops span %0d want 3 span 2", npop, last_pop - first_pop); end
    checks++; if (first_vis != first_pop + 1) begin errors++; $display("FAIL single_latency: got visible t=%0d want %0d", first_vis, first_pop + 1); end
    checks++; if (obs_out.size() != 3) begin errors++; $display("FAIL single_count: got %0d want 3", obs_out.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_out[i] !== 32'hA000_0001 + 32'(i)) begin errors++; $display("FAIL single_word%0d: got %h want %h", i, obs_out[i], 32'hA000_0001 + 32'(i)); end
      end
    end
    checks++; if (s_cnt0 !== 4'd3 || s_cnt1 !== 4'd0) begin errors++; $display("FAIL single_cnt: got %0d/%0d want 3/0", s_cnt0, s_cnt1); end
  endtask

  task automatic test_round_robin();
    int i0, i1, k, src;
    int seg_n[6];
    logic [31:0] want;
    bit contiguous;
    seg_n = '{4, 4, 4, 4, 2, 2};
    do_reset();
    enable = 2'b11; out_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q0.push_back(32'hB000_0000 + 32'(i));
      q1.push_back(32'hC000_0000 + 32'(i));
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++; if (s_rd !== e_rd) begin errors++; $display("FAIL rr_rd: got %b want %b", s_rd, e_rd); end
      checks++; if (s_empty !== e_empty) begin errors++; $display("FAIL rr_empty: got %b want %b", s_empty, e_empty); end
    end
    checks++; if (obs_out.size() != 20) begin errors++; $display("FAIL rr_count: got %0d want 20", obs_out.size()); end
    else begin
      i0 = 0; i1 = 0; k = 0;
      for (int s = 0; s < 6; s++) begin
        src = s % 2;
        for (int j = 0; j < seg_n[s]; j++) begin
          if (src == 0) begin want = 32'hB000_0000 + 32'(i0); i0++; end
          else          begin want = 32'hC000_0000 + 32'(i1); i1++; end
          checks++; if (obs_out[k] !== want) begin errors++; $display("FAIL rr_word%0d: got %h want %h", k, obs_out[k], want); end
          k++;
        end
      end
      contiguous = 1'b1;
      for (int j = 1; j < 18; j++) if (obs_tick[j] != obs_tick[j-1] + 1) contiguous = 1'b0;
      checks++; if (!contiguous) begin errors++; $display("FAIL rr_gapless: got gap in first 18 words want none"); end
    end
    checks++; if (s_cnt0 !== 4'd10 || s_cnt1 !== 4'd10) begin errors++; $display("FAIL rr_cnt: got %0d/%0d want 10/10", s_cnt0, s_cnt1); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[6];
    int npop;
    bit contiguous;
    do_reset();
    enable = 2'b01; out_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin w[i] = $urandom; q0.push_back(w[i]); end
    npop = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (s_rd !== e_rd) begin errors++; $display("FAIL bp_rd: got %b want %b", s_rd, e_rd); end
      if (s_rd[0]) npop++;
    end
    checks++; if (npop != 2) begin errors++; $display("FAIL bp_pops: got %0d want 2", npop); end
    checks++; if (s_empty !== 1'b0 || s_rd[0] !== 1'b0) begin errors++; $display("FAIL bp_stall: got empty=%b rd=%b want 0/0", s_empty, s_rd[0]); end
    out_rd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (!e_empty && s_data !== e_data) begin errors++; $display("FAIL bp_data: got %h want %h", s_data, e_data); end
    end
    checks++; if (obs_out.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", obs_out.size()); end
    else begin
      contiguous = 1'b1;
      for (int i = 0; i < 6; i++) begin
        checks++; if (obs_out[i] !== w[i]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, obs_out[i], w[i]); end
        if (i > 0 && obs_tick[i] != obs_tick[i-1] + 1) contiguous = 1'b0;
      end
      checks++; if (!contiguous) begin errors++; $display("FAIL bp_stream: got gap want 1 word/cycle"); end
    end
  endtask

  task automatic test_enable_drop();
    logic [31:0] want[6];
    do_reset();
    for (int i = 0; i < 6; i++) q1.push_back(32'hD100_0000 + 32'(i));
    for (int i = 0; i < 4; i++) q0.push_back(32'hE000_0000 + 32'(i));
    want = '{32'hD100_0000, 32'hD100_0001, 32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
    enable = 2'b10; out_rd = 1'b1;
    tick();
    enable = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (s_rd !== 2'b10) begin errors++; $display("FAIL en_burst1: got %b want 10", s_rd); end
    end
    enable = 2'b01;
    tick();
    checks++; if (s_rd !== 2'b00) begin errors++; $display("FAIL en_drop: got %b want 00", s_rd); end
    tick();
    checks++; if (s_rd !== 2'b01) begin errors++; $display("FAIL en_switch: got %b want 01", s_rd); end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (obs_out.size() != 6) begin errors++; $display("FAIL en_count: got %0d want 6", obs_out.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (obs_out[i] !== want[i]) begin errors++; $display("FAIL en_word%0d: got %h want %h", i, obs_out[i], want[i]); end
      end
    end
  endtask

  task automatic test_cnt_clr();
    int n;
    do_reset();
    enable = 2'b01; out_rd = 1'b1;
    for (int i = 0; i < 10; i++) q0.push_back($urandom);
    n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      tick();
      if (s_rd[0]) n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL clr_timeout: got %0d pops want 5", n); end
    cnt_clr = 1'b1;
    tick();
    checks++; if (s_rd[0] !== 1'b1 || s_cnt0 !== 4'd5) begin errors++; $display("FAIL clr_setup: got rd=%b cnt=%0d want 1/5", s_rd[0], s_cnt0); end
    cnt_clr = 1'b0;
    tick();
    checks++; if (s_cnt0 !== 4'd0) begin errors++; $display("FAIL clr_prio: got %0d want 0", s_cnt0); end
    do_reset();
    enable = 2'b01; out_rd = 1'b1;
    for (int i = 0; i < 17; i++) q0.push_back($urandom);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_rd[0]) n++;
    end
    checks++; if (n != 17 || s_cnt0 !== 4'd1) begin errors++; $display("FAIL clr_wrap: got pops=%0d cnt=%0d want 17/1", n, s_cnt0); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    enable = 2'b11; out_rd = 1'b0;
    for (int i = 0; i < 8; i++) q1.push_back(32'hF100_0000 + 32'(i));
    tick(); tick(); tick();
    checks++; if (s_empty !== 1'b0 || e_empty !== 1'b0) begin errors++; $display("FAIL rstmid_setup: got empty=%b want 0", s_empty); end
    for (int i = 0; i < 4; i++) q0.push_back(32'hF000_0000 + 32'(i));
    rst = 1'b1; out_rd = 1'b1;
    tick();
    checks++; if (s_rd !== 2'b00) begin errors++; $display("FAIL rstmid_read: got %b want 00", s_rd); end
    rst = 1'b0; out_rd = 1'b0;
    tick();
    checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", s_empty); end
    checks++; if (s_cnt0 !== '0 || s_cnt1 !== '0) begin errors++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", s_cnt0, s_cnt1); end
    out_rd = 1'b1;
    n = 0;
    while (n < 10) begin
      tick();
      n++;
      if (s_rd != 2'b00) break;
    end
    checks++; if (s_rd !== 2'b01) begin errors++; $display("FAIL rstmid_first: got %b want 01", s_rd); end
  endtask

  task automatic test_random();
    do_reset();
    enable = 2'b11;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) enable = 2'($urandom_range(0, 3));
      out_rd  = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      if (q0.size() < 8 && $urandom_range(0, 2) == 0) q0.push_back($urandom);
      if (q1.size() < 8 && $urandom_range(0, 2) == 0) q1.push_back($urandom);
      tick();
      checks++; if (s_rd !== e_rd) begin errors++; $display("FAIL rnd_rd c=%0d: got %b want %b", c, s_rd, e_rd); end
      checks++; if (s_empty !== e_empty) begin errors++; $display("FAIL rnd_empty c=%0d: got %b want %b", c, s_empty, e_empty); end
      checks++; if (!e_empty && s_data !== e_data) begin errors++; $display("FAIL rnd_data c=%0d: got %h want %h", c, s_data, e_data); end
      checks++; if (s_cnt0 !== e_cnt0 || s_cnt1 !== e_cnt1) begin errors++; $display("FAIL rnd_cnt c=%0d: got %0d/%0d want %0d/%0d", c, s_cnt0, s_cnt1, e_cnt0, e_cnt1); end
    end
    cnt_clr = 1'b0;
  endtask

  initial begin
    m_serve = -1; m_last = 1; m_burst = 0; m_cnt0 = 0; m_cnt1 = 0;
    rst = 1'b1; enable = 2'b00; cnt_clr = 1'b0; out_rd = 1'b0;
    drive_src();
    @(negedge clk);
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_enable_drop();
    test_cnt_clr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
